// File: rtl/barrel_shifter.sv
// n-bit barrel shifter: logical left, logical right and arithmetic right.
// Combinational result plus a registered copy for pipelined consumers.
`timescale 1ns/1ps
module barrel_shifter #(
  parameter int n = 16,
  parameter int m = $clog2(n)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] data,
  input  logic [m-1:0] shamt,
  input  logic         dir,
  input  logic         arith,
  output logic [n-1:0] out,
  output logic [n-1:0] out_q
);

  logic         fill;
  logic [n-1:0] rev_in;
  logic [n-1:0] rev_out;
  logic [m:0][n-1:0] st;

  assign fill = arith & dir & data[n-1];

  always_comb begin
    rev_in = '0;
    for (int i = 0; i < n; i++)
      rev_in[i] = data[n-1-i];
  end

  assign st[0] = dir ? rev_in : data;

  // Right shifts run through the same left stages on a bit-reversed operand
  for (genvar k = 0; k < m; k++) begin : g_stage
    localparam int s = 1 << k;
    for (genvar i = 0; i < n; i++) begin : g_bit
      if (i >= s) begin : g_mv
        assign st[k+1][i] = shamt[k] ? st[k][i-s] : st[k][i];
      end else begin : g_fill
        assign st[k+1][i] = shamt[k] ? fill : st[k][i];
      end
    end
  end

  always_comb begin
    rev_out = '0;
    for (int i = 0; i < n; i++)
      rev_out[i] = st[m][n-1-i];
  end

  assign out = dir ? rev_out : st[m];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_q <= '0;
    else
      out_q <= out;
  end

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed and random checks of barrel_shifter out and out_q.
// Expected values come from hand-computed vectors and shift operators.
`timescale 1ns/1ps
module tb_barrel_shifter;

  logic        clk;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  shamt;
  logic        dir;
  logic        arith;
  logic [15:0] out;
  logic [15:0] out_q;

  int ncmp;
  int nerr;

  barrel_shifter #(.n(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (data),
    .shamt (shamt),
    .dir   (dir),
    .arith (arith),
    .out   (out),
    .out_q (out_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [15:0] d, input logic [3:0] s,
                       input logic dr, input logic ar);
    data  = d;
    shamt = s;
    dir   = dr;
    arith = ar;
    #10;
  endtask

  initial begin
    logic [15:0] exp;
    ncmp  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    data  = '0;
    shamt = '0;
    dir   = 1'b0;
    arith = 1'b0;

    // reset held: out_q stays 0 while out follows inputs
    @(negedge clk);
    apply(16'hA5A5, 4'd1, 1'b0, 1'b0);
    chk("rst_out_tracks", out, 16'h4B4A);
    chk("rst_outq", out_q, 16'h0000);
    apply(16'h00F0, 4'd4, 1'b1, 1'b0);
    chk("rst_out_tracks2", out, 16'h000F);
    chk("rst_outq2", out_q, 16'h0000);

    // directed combinational vectors
    apply(16'hA5A5, 4'd0,  1'b0, 1'b0); chk("l0", out, 16'hA5A5);
    apply(16'hA5A5, 4'd15, 1'b0, 1'b0); chk("l15", out, 16'h8000);
    apply(16'hA5A5, 4'd15, 1'b0, 1'b1); chk("l15_ar", out, 16'h8000);
    apply(16'hA5A5, 4'd0,  1'b1, 1'b0); chk("r0", out, 16'hA5A5);
    apply(16'hA5A5, 4'd15, 1'b1, 1'b0); chk("r15", out, 16'h0001);
    apply(16'hA5A5, 4'd4,  1'b1, 1'b0); chk("r4", out, 16'h0A5A);
    apply(16'h1A2B, 4'd15, 1'b1, 1'b1); chk("a15_pos", out, 16'h0000);
    apply(16'hF0F0, 4'd15, 1'b1, 1'b1); chk("a15_neg", out, 16'hFFFF);
    apply(16'hF0F0, 4'd4,  1'b1, 1'b1); chk("a4_neg", out, 16'hFF0F);
    apply(16'hF0F0, 4'd0,  1'b1, 1'b1); chk("a0", out, 16'hF0F0);
    apply(16'hF0F0, 4'd4,  1'b1, 1'b0); chk("r4_neg", out, 16'h0F0F);
    apply(16'h8001, 4'd1,  1'b0, 1'b0); chk("l1", out, 16'h0002);
    apply(16'h8000, 4'd8,  1'b1, 1'b1); chk("a8", out, 16'hFF80);

    // random vectors against shift-operator model
    for (int i = 0; i < 48; i++) begin
      apply(16'($urandom), 4'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom));
      if (!dir)
        exp = data << shamt;
      else if (!arith)
        exp = data >> shamt;
      else
        exp = $signed(data) >>> shamt;
      chk($sformatf("rnd%0d", i), out, exp);
    end

    // reset release mid-operation, then register load
    @(negedge clk);
    rst_n = 1'b1;
    data  = 16'hA5A5;
    shamt = 4'd4;
    dir   = 1'b0;
    arith = 1'b0;
    @(posedge clk);
    #1;
    chk("outq_load", out_q, 16'h5A50);
    data = 16'h0F0F;
    shamt = 4'd0;
    @(posedge clk);
    #1;
    chk("outq_load2", out_q, 16'h0F0F);

    // asynchronous clear between edges
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_clr", out_q, 16'h0000);
    @(posedge clk);
    #1;
    chk("clr_hold", out_q, 16'h0000);
    chk("clr_out", out, 16'h0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
